// File: rtl/inst_exec_unit_pkg.sv
// Shared definitions for the execute unit and the fetch sequencer:
// opcodes, predicate codes, step one-hots, sequencer states, ir layout.
package inst_exec_unit_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDI = 8'h01;
  localparam logic [7:0] OP_MOV = 8'h02;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_SUB = 8'h04;
  localparam logic [7:0] OP_AND = 8'h05;
  localparam logic [7:0] OP_OR  = 8'h06;
  localparam logic [7:0] OP_XOR = 8'h07;
  localparam logic [7:0] OP_MUL = 8'h08;
  localparam logic [7:0] OP_JMP = 8'h10;
  localparam logic [7:0] OP_OUT = 8'h20;
  localparam logic [7:0] OP_HLT = 8'hFF;

  localparam logic [1:0] PR_ALW = 2'd0;
  localparam logic [1:0] PR_Z   = 2'd1;
  localparam logic [1:0] PR_C   = 2'd2;
  localparam logic [1:0] PR_NZ  = 2'd3;

  localparam logic [15:0] CLK_0 = 16'h0001;
  localparam logic [15:0] CLK_1 = 16'h0002;
  localparam logic [15:0] CLK_2 = 16'h0004;
  localparam logic [15:0] CLK_3 = 16'h0008;
  localparam logic [15:0] CLK_4 = 16'h0010;
  localparam logic [15:0] CLK_5 = 16'h0020;
  localparam logic [15:0] CLK_6 = 16'h0040;
  localparam logic [15:0] CLK_7 = 16'h0080;
  localparam logic [15:0] CLK_8 = 16'h0100;
  localparam logic [15:0] CLK_9 = 16'h0200;
  localparam logic [15:0] CLK_A = 16'h0400;
  localparam logic [15:0] CLK_B = 16'h0800;
  localparam logic [15:0] CLK_C = 16'h1000;
  localparam logic [15:0] CLK_D = 16'h2000;
  localparam logic [15:0] CLK_E = 16'h4000;
  localparam logic [15:0] CLK_F = 16'h8000;

  typedef enum logic [1:0] {
    ST_IF  = 2'd0,
    ST_IE  = 2'd1,
    ST_HLT = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [7:0] op;
    logic [1:0] pred;
    logic [1:0] rsvd;
    logic [1:0] rs;
    logic [1:0] rd;
    logic [7:0] imm;
    logic [7:0] addr;
  } ir_t;

  function automatic logic pred_true(
    input logic [1:0] p,
    input logic       z,
    input logic       c
  );
    logic r;
    r = 1'b1;
    unique case (p)
      PR_ALW: r = 1'b1;
      PR_Z:   r = z;
      PR_C:   r = c;
      PR_NZ:  r = !z;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inst_exec_unit_if.sv
// Output port of the execute unit: valid/ready with data.
// master: drives out_data/out_valid; slave: drives out_ready.
interface inst_exec_unit_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/inst_exec_unit_mul.sv
// Shift-add multiplier: start loads M/Q and clears P; each step is one
// add-and-shift. lo/hi are the product after the current step; done flags the last step.
module exec_mul #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] m_in,
  input  logic [DATA_W-1:0] q_in,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] p_q;
  logic [DATA_W-1:0] m_q;
  logic [DATA_W-1:0] q_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W:0]   sum;
  logic [2*DATA_W:0] cat;
  logic              unused_lsb;

  assign sum = {1'b0, p_q} + (q_q[0] ? {1'b0, m_q} : '0);

  // {carry,P,Q} shifted right by one; bit 0 is the consumed multiplier bit
  assign cat = {sum, q_q};
  assign hi  = cat[2*DATA_W:DATA_W+1];
  assign lo  = cat[DATA_W:1];
  assign unused_lsb = cat[0];

  assign done = step && (cnt_q == CW'(DATA_W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q   <= '0;
      m_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else if (start) begin
      p_q   <= '0;
      m_q   <= m_in;
      q_q   <= q_in;
      cnt_q <= '0;
    end else if (step) begin
      p_q   <= hi;
      q_q   <= lo;
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/inst_exec_unit.sv
// Execute unit: decodes ir against the step one-hot clks, owns R0..R3, {C,Z},
// multiplier and output port. Returns condition/end/jmp/hlt to the sequencer.
module inst_exec_unit
  import inst_exec_unit_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic [15:0] clks,
  input  logic [1:0]  state,
  output logic        inst_condition,
  output logic        end_inst,
  output logic        jmp_inst,
  output logic        hlt_inst,
  output logic [7:0]  jmp_address,
  output logic [1:0]  flags,
  output logic        illegal,
  inst_exec_unit_if.master port
);

  ir_t d;
  assign d = ir;

  logic [DATA_W-1:0] rf [4];
  logic [DATA_W-1:0] t_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              z_q;
  logic              c_q;
  logic              ill_q;

  logic [DATA_W-1:0] rs_v;
  logic [DATA_W-1:0] rd_v;
  logic [DATA_W-1:0] imm_v;

  assign rs_v  = rf[d.rs];
  assign rd_v  = rf[d.rd];
  assign imm_v = DATA_W'(d.imm);

  logic is_nop, is_ldi, is_mov, is_add;
  logic is_sub, is_and, is_or,  is_xor;
  logic is_mul, is_jmp, is_out, is_hlt;
  logic is_ill;

  assign is_nop = d.op == OP_NOP;
  assign is_ldi = d.op == OP_LDI;
  assign is_mov = d.op == OP_MOV;
  assign is_add = d.op == OP_ADD;
  assign is_sub = d.op == OP_SUB;
  assign is_and = d.op == OP_AND;
  assign is_or  = d.op == OP_OR;
  assign is_xor = d.op == OP_XOR;
  assign is_mul = MUL_EN && (d.op == OP_MUL);
  assign is_jmp = d.op == OP_JMP;
  assign is_out = d.op == OP_OUT;
  assign is_hlt = d.op == OP_HLT;

  assign is_ill = !(is_nop | is_ldi | is_mov | is_add |
                    is_sub | is_and | is_or  | is_xor |
                    is_mul | is_jmp | is_out | is_hlt);

  logic s0, s1, s_last, s_mul;
  assign s0     = |(clks & CLK_0);
  assign s1     = |(clks & CLK_1);
  assign s_last = clks[DATA_W];
  assign s_mul  = |clks[DATA_W:1];

  logic unused_ok;
  assign unused_ok = ^{d.rsvd, clks};

  logic go;
  assign inst_condition = pred_true(d.pred, z_q, c_q);
  assign go = (state == ST_IE) && inst_condition;

  assign jmp_address = d.addr;
  assign flags       = {c_q, z_q};
  assign illegal     = ill_q;

  assign port.out_data  = out_data_q;
  assign port.out_valid = out_valid_q;

  logic fin;
  always_comb begin
    fin = 1'b0;
    unique case (1'b1)
      is_add, is_sub: fin = s1;
      is_mul:         fin = s_last;
      is_out:         fin = out_valid_q & port.out_ready;
      is_hlt, is_ill: fin = 1'b0;
      default:        fin = s0;
    endcase
  end

  assign end_inst = fin & inst_condition;
  assign jmp_inst = is_jmp & inst_condition;
  assign hlt_inst = (is_hlt | is_ill) & s0 & inst_condition;

  // ADD/SUB share one adder; bit DATA_W is carry (add) or borrow (sub)
  logic [DATA_W:0] arith;
  assign arith = is_sub ? ({1'b0, rd_v} - {1'b0, t_q})
                        : ({1'b0, rd_v} + {1'b0, t_q});

  logic [DATA_W-1:0] logic_r;
  assign logic_r = is_and ? (rd_v & rs_v) :
                   is_or  ? (rd_v | rs_v) :
                            (rd_v ^ rs_v);

  logic              mul_start;
  logic              mul_step;
  logic              mul_done;
  logic [DATA_W-1:0] mul_lo;
  logic [DATA_W-1:0] mul_hi;

  assign mul_start = go & is_mul & s0;
  assign mul_step  = go & is_mul & s_mul;

  exec_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .step  (mul_step),
    .m_in  (rs_v),
    .q_in  (rd_v),
    .lo    (mul_lo),
    .hi    (mul_hi),
    .done  (mul_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
      t_q         <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      ill_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // handshake retires the port regardless of sequencer state
      if (out_valid_q && port.out_ready) out_valid_q <= 1'b0;
      if (go) begin
        unique case (1'b1)
          is_ldi: if (s0) rf[d.rd] <= imm_v;
          is_mov: if (s0) rf[d.rd] <= rs_v;
          is_add, is_sub: begin
            if (s0) t_q <= rs_v;
            if (s1) begin
              rf[d.rd] <= arith[DATA_W-1:0];
              c_q      <= arith[DATA_W];
              z_q      <= arith[DATA_W-1:0] == '0;
            end
          end
          is_and, is_or, is_xor: begin
            if (s0) begin
              rf[d.rd] <= logic_r;
              z_q      <= logic_r == '0;
              c_q      <= 1'b0;
            end
          end
          is_mul: begin
            if (mul_done) begin
              rf[d.rd] <= mul_lo;
              c_q      <= mul_hi != '0;
              z_q      <= mul_lo == '0;
            end
          end
          // load only on the first IE cycle; held stable until accepted
          is_out: begin
            if (!out_valid_q) begin
              out_data_q  <= rs_v;
              out_valid_q <= 1'b1;
            end
          end
          is_ill: if (s0) ill_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_exec_unit.sv
// Bench for inst_exec_unit: acts as the fetch sequencer, drives random and
// directed instructions, compares against an arithmetic reference model.
module tb_inst_exec_unit;
  import inst_exec_unit_pkg::*;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ir = '0;
  logic [15:0] clks = '0;
  logic [1:0]  state = 2'd0;
  logic        inst_condition;
  logic        end_inst;
  logic        jmp_inst;
  logic        hlt_inst;
  logic [7:0]  jmp_address;
  logic [1:0]  flags;
  logic        illegal;

  inst_exec_unit_if #(.DATA_W(W)) port ();

  inst_exec_unit #(
    .DATA_W (W),
    .MUL_EN (1'b1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ir             (ir),
    .clks           (clks),
    .state          (state),
    .inst_condition (inst_condition),
    .end_inst       (end_inst),
    .jmp_inst       (jmp_inst),
    .hlt_inst       (hlt_inst),
    .jmp_address    (jmp_address),
    .flags          (flags),
    .illegal        (illegal),
    .port           (port)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int m_r [4] = '{0, 0, 0, 0};
  bit m_z = 0;
  bit m_c = 0;
  bit m_ill = 0;

  logic [7:0] op_tab [12] = '{OP_NOP, OP_LDI, OP_LDI, OP_LDI,
                              OP_MOV, OP_ADD, OP_SUB, OP_AND,
                              OP_OR,  OP_XOR, OP_MUL, OP_JMP};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_pred(input logic [1:0] p);
    case (p)
      2'd0:    return 1'b1;
      2'd1:    return m_z;
      2'd2:    return m_c;
      default: return !m_z;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_z = 0;
    m_c = 0;
    m_ill = 0;
  endtask

  task automatic run_inst(input logic [7:0] op, input logic [1:0] pr,
                          input logic [1:0] rs, input logic [1:0] rd,
                          input logic [7:0] imm, input logic [7:0] addr,
                          input int stall);
    bit cond, ill_e, ends_e, done;
    bit s_cond, s_end, s_hlt, s_jmp;
    int exp_step, k, a, b, res;
    cond  = m_pred(pr);
    ill_e = !(op inside {OP_NOP, OP_LDI, OP_MOV, OP_ADD, OP_SUB,
                         OP_AND, OP_OR, OP_XOR, OP_MUL, OP_JMP,
                         OP_OUT, OP_HLT});
    ends_e = cond && !ill_e && (op != OP_HLT);
    if (op == OP_ADD || op == OP_SUB) exp_step = 1;
    else if (op == OP_MUL) exp_step = W;
    else if (op == OP_OUT) exp_step = (stall > 1) ? stall : 1;
    else exp_step = 0;
    a = m_r[rd];
    b = m_r[rs];
    ir = {op, pr, 2'b00, rs, rd, imm, addr};
    state = 2'd1;
    clks = 16'h0001;
    done = 0;
    k = 0;
    s_cond = 0; s_end = 0; s_hlt = 0; s_jmp = 0;
    while (!done) begin
      if (op == OP_OUT) port.out_ready = (k >= stall);
      else port.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      s_cond = inst_condition;
      s_end  = end_inst;
      s_hlt  = hlt_inst;
      s_jmp  = jmp_inst;
      if (op == OP_OUT && cond && k >= 1) begin
        check("out_valid", 32'(port.out_valid), 1);
        check("out_data", 32'(port.out_data), b);
      end
      if (!s_cond || s_end || s_hlt || k >= 40) done = 1;
      @(posedge clk);
      #1;
      if (!done) begin
        k++;
        clks = {clks[14:0], clks[15]};
      end
    end
    // one IF cycle with a live step bit: nothing may be written
    state = 2'd0;
    clks = 16'h0001;
    port.out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("cond", 32'(s_cond), 32'(cond));
    check("end", 32'(s_end), 32'(ends_e));
    check("hlt", 32'(s_hlt), 32'(cond && (ill_e || op == OP_HLT)));
    check("jmp", 32'(s_jmp), 32'(cond && op == OP_JMP));
    if (ends_e) check("step", k, exp_step);
    if (op == OP_JMP) check("jmp_addr", 32'(jmp_address), 32'(addr));
    if (cond) begin
      case (op)
        OP_LDI: m_r[rd] = imm;
        OP_MOV: m_r[rd] = b;
        OP_ADD: begin
          res = a + b;
          m_r[rd] = res & 255;
          m_c = res > 255;
          m_z = (res & 255) == 0;
        end
        OP_SUB: begin
          res = a - b;
          m_r[rd] = res & 255;
          m_c = a < b;
          m_z = (res & 255) == 0;
        end
        OP_AND, OP_OR, OP_XOR: begin
          res = (op == OP_AND) ? (a & b) : (op == OP_OR) ? (a | b) : (a ^ b);
          m_r[rd] = res;
          m_c = 0;
          m_z = res == 0;
        end
        OP_MUL: begin
          res = a * b;
          m_r[rd] = res & 255;
          m_c = res > 255;
          m_z = (res & 255) == 0;
        end
        OP_NOP, OP_JMP, OP_OUT, OP_HLT: ;
        default: m_ill = 1;
      endcase
    end
    check("flags", 32'(flags), 32'({m_c, m_z}));
    check("illegal", 32'(illegal), 32'(m_ill));
    if (op == OP_OUT) check("out_idle", 32'(port.out_valid), 0);
  endtask

  task automatic dump_regs();
    for (int i = 0; i < 4; i++)
      run_inst(OP_OUT, 2'd0, 2'(i), 2'd0, 8'h00, 8'h00, $urandom_range(0, 3));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    port.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", 32'(flags), 0);
    check("rst_illegal", 32'(illegal), 0);
    check("rst_out_valid", 32'(port.out_valid), 0);
    check("rst_out_data", 32'(port.out_data), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_inst(OP_LDI, 0, 0, 1, 8'h05, 0, 0);
    run_inst(OP_LDI, 0, 0, 2, 8'h07, 0, 0);
    run_inst(OP_ADD, 0, 2, 1, 0, 0, 0);
    run_inst(OP_OUT, 0, 1, 0, 0, 0, 0);

    run_inst(OP_LDI, 0, 0, 0, 8'hFF, 0, 0);
    run_inst(OP_LDI, 0, 0, 3, 8'h01, 0, 0);
    run_inst(OP_ADD, 0, 3, 0, 0, 0, 0);
    run_inst(OP_JMP, PR_Z, 0, 0, 0, 8'h40, 0);
    run_inst(OP_JMP, PR_C, 0, 0, 0, 8'h40, 0);
    run_inst(OP_LDI, 0, 0, 0, 8'h00, 0, 0);
    run_inst(OP_LDI, 0, 0, 1, 8'h01, 0, 0);
    run_inst(OP_SUB, 0, 1, 0, 0, 0, 0);
    run_inst(OP_OUT, 0, 0, 0, 0, 0, 2);

    run_inst(OP_LDI, 0, 0, 0, 8'h01, 0, 0);
    run_inst(OP_ADD, 0, 1, 0, 0, 0, 0);
    run_inst(OP_JMP, PR_Z, 0, 0, 0, 8'h22, 0);

    run_inst(OP_LDI, 0, 0, 1, 8'h10, 0, 0);
    run_inst(OP_LDI, 0, 0, 2, 8'h11, 0, 0);
    run_inst(OP_MUL, 0, 2, 1, 0, 0, 0);
    run_inst(OP_LDI, 0, 0, 1, 8'h03, 0, 0);
    run_inst(OP_LDI, 0, 0, 2, 8'h04, 0, 0);
    run_inst(OP_MUL, 0, 2, 1, 0, 0, 0);
    run_inst(OP_OUT, 0, 1, 0, 0, 0, 20);

    for (int i = 0; i < 300; i++) begin
      logic [7:0] op;
      logic [1:0] pr;
      op = op_tab[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) == 0) op = OP_OUT;
      pr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      run_inst(op, pr, 2'($urandom), 2'($urandom), 8'($urandom),
               8'($urandom), $urandom_range(0, 4));
      if (i % 25 == 24) dump_regs();
    end
    dump_regs();

    run_inst(OP_HLT, 0, 0, 0, 0, 0, 0);
    run_inst(8'h77, 0, 0, 0, 0, 0, 0);

    run_inst(OP_LDI, 0, 0, 2, 8'hA5, 0, 0);
    ir = {OP_OUT, 2'b00, 2'b00, 2'd2, 2'd0, 16'h0000};
    state = 2'd1;
    clks = 16'h0001;
    port.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stall_valid", 32'(port.out_valid), 1);
    #2 reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(port.out_valid), 0);
    check("rst_out_data", 32'(port.out_data), 0);
    check("rst_illegal", 32'(illegal), 0);
    state = 2'd0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    run_inst(OP_LDI, 0, 0, 1, 8'h9C, 0, 0);
    run_inst(OP_LDI, 0, 0, 2, 8'h37, 0, 0);
    run_inst(OP_LDI, 0, 0, 0, 8'hFF, 0, 0);
    run_inst(OP_LDI, 0, 0, 3, 8'h01, 0, 0);
    run_inst(OP_ADD, 0, 3, 0, 0, 0, 0);
    run_inst(8'h77, 0, 0, 0, 0, 0, 0);
    ir = {OP_MUL, 2'b00, 2'b00, 2'd2, 2'd1, 16'h0000};
    state = 2'd1;
    clks = 16'h0001;
    repeat (4) begin
      @(posedge clk);
      #1;
      clks = {clks[14:0], clks[15]};
    end
    #2 reset = 1'b0;
    #1;
    check("mul_rst_flags", 32'(flags), 0);
    check("mul_rst_illegal", 32'(illegal), 0);
    check("mul_rst_valid", 32'(port.out_valid), 0);
    state = 2'd0;
    clks = 16'h0000;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    dump_regs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
